// File: rtl/pic_pkg.sv
// Shared memory map, bit positions and address decode for the PIC16 file register stage.
package pic_pkg;

  // Special function register offsets within a bank.
  localparam logic [6:0] SFR_INDF   = 7'h00;
  localparam logic [6:0] SFR_TMR0   = 7'h01;  // banks 0 and 2
  localparam logic [6:0] SFR_OPTION = 7'h01;  // banks 1 and 3
  localparam logic [6:0] SFR_PCL    = 7'h02;
  localparam logic [6:0] SFR_STATUS = 7'h03;
  localparam logic [6:0] SFR_FSR    = 7'h04;
  localparam logic [6:0] SFR_PCLATH = 7'h0A;
  localparam logic [6:0] SFR_INTCON = 7'h0B;

  // General purpose RAM windows.
  localparam logic [6:0] GPR_LO      = 7'h20;
  localparam logic [6:0] GPR_HI      = 7'h6F;
  localparam logic [6:0] COMMON_LO   = 7'h70;
  localparam int         RAM_DEPTH   = 336;
  localparam logic [8:0] COMMON_BASE = 9'd320;

  // OPTION_REG bit positions.
  localparam int OPT_NRBPU  = 7;
  localparam int OPT_INTEDG = 6;
  localparam int OPT_T0CS   = 5;
  localparam int OPT_T0SE   = 4;
  localparam int OPT_PSA    = 3;

  // INTCON bit positions.
  localparam int INT_GIE  = 7;
  localparam int INT_PEIE = 6;
  localparam int INT_T0IE = 5;
  localparam int INT_INTE = 4;
  localparam int INT_RBIE = 3;
  localparam int INT_T0IF = 2;
  localparam int INT_INTF = 1;
  localparam int INT_RBIF = 0;

  typedef enum logic [3:0] {
    SEL_ZERO   = 4'd0,
    SEL_TMR0   = 4'd1,
    SEL_OPTION = 4'd2,
    SEL_PCL    = 4'd3,
    SEL_STATUS = 4'd4,
    SEL_FSR    = 4'd5,
    SEL_PCLATH = 4'd6,
    SEL_INTCON = 4'd7
  } rd_sel_e;

  typedef struct packed {
    rd_sel_e    sel;
    logic       ram_hit;
    logic [8:0] ram_idx;
  } decode_t;

  // Start of each bank's 80-byte slice in the folded RAM.
  function automatic logic [8:0] bank_base(input logic [1:0] bank);
    logic [8:0] base;
    case (bank)
      2'd0:    base = 9'd0;
      2'd1:    base = 9'd80;
      2'd2:    base = 9'd160;
      2'd3:    base = 9'd240;
      default: base = 9'd0;
    endcase
    return base;
  endfunction

  // Map a 9-bit data address to a read source and, for RAM, a folded array index.
  function automatic decode_t decode_addr(input logic [8:0] addr);
    decode_t    d;
    logic [6:0] off;
    off       = addr[6:0];
    d.sel     = SEL_ZERO;
    d.ram_hit = 1'b0;
    d.ram_idx = 9'd0;
    case (off)
      SFR_INDF:   d.sel = SEL_ZERO;
      SFR_TMR0: begin
        if (addr[7]) begin
          d.sel = SEL_OPTION;
        end else begin
          d.sel = SEL_TMR0;
        end
      end
      SFR_PCL:    d.sel = SEL_PCL;
      SFR_STATUS: d.sel = SEL_STATUS;
      SFR_FSR:    d.sel = SEL_FSR;
      SFR_PCLATH: d.sel = SEL_PCLATH;
      SFR_INTCON: d.sel = SEL_INTCON;
      default: begin
        if (off >= COMMON_LO) begin
          d.ram_hit = 1'b1;
          d.ram_idx = COMMON_BASE + {5'b00000, off[3:0]};
        end else if ((off >= GPR_LO) && (off <= GPR_HI)) begin
          d.ram_hit = 1'b1;
          d.ram_idx = bank_base(addr[8:7]) + {2'b00, off - GPR_LO};
        end else begin
          d.ram_hit = 1'b0;
        end
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/pic_file_register_timer0.sv
// Timer0: T0CKI synchroniser, edge select, 8-bit prescaler, TMR0 and overflow pulse.
module pic_timer0 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sync,
  input  logic       i_t0cki,
  input  logic       i_t0cs,
  input  logic       i_t0se,
  input  logic       i_psa,
  input  logic [2:0] i_ps,
  input  logic       i_we,
  input  logic [7:0] i_wdata,
  output logic [7:0] o_tmr0,
  output logic       o_ovf
);

  logic       r_t0_s1;
  logic       r_t0_s2;
  logic       r_t0_prev;
  logic [7:0] r_psc;
  logic [7:0] r_tmr0;
  logic       w_rise;
  logic       w_fall;
  logic       w_edge;
  logic       w_tick;
  logic [7:0] w_psc_max;
  logic       w_psc_hit;
  logic       w_inc;
  logic       w_ovf;

  // Two-stage synchroniser on the T0CKI pin plus the previous-sample edge register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_t0_s1   <= 1'b0;
      r_t0_s2   <= 1'b0;
      r_t0_prev <= 1'b0;
    end else begin
      r_t0_s1   <= i_t0cki;
      r_t0_s2   <= r_t0_s1;
      r_t0_prev <= r_t0_s2;
    end
  end

  // Select the tick source and decide whether TMR0 advances and overflows this cycle.
  always_comb begin
    w_rise = r_t0_s2 & ~r_t0_prev;
    w_fall = ~r_t0_s2 & r_t0_prev;
    if (i_t0se) begin
      w_edge = w_fall;
    end else begin
      w_edge = w_rise;
    end
    if (i_t0cs) begin
      w_tick = w_edge;
    end else begin
      w_tick = i_sync;
    end
    // Terminal count 2^(PS+1)-1: 0x01 for PS=0 up to 0xFF for PS=7.
    w_psc_max = 8'hFF >> (3'd7 - i_ps);
    w_psc_hit = (r_psc == w_psc_max);
    if (i_psa) begin
      w_inc = w_tick;
    end else begin
      w_inc = w_tick & w_psc_hit;
    end
    // A software load suppresses the increment, so it cannot overflow either.
    w_ovf = w_inc & (r_tmr0 == 8'hFF) & ~i_we;
  end

  // Prescaler and TMR0 update; a TMR0 write loads the counter and clears the prescaler.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_psc  <= 8'h00;
      r_tmr0 <= 8'h00;
    end else if (i_we) begin
      r_psc  <= 8'h00;
      r_tmr0 <= i_wdata;
    end else begin
      if (w_inc) begin
        r_tmr0 <= r_tmr0 + 8'd1;
      end
      if (w_tick & ~i_psa) begin
        if (w_psc_hit) begin
          r_psc <= 8'h00;
        end else begin
          r_psc <= r_psc + 8'd1;
        end
      end
    end
  end

  assign o_tmr0 = r_tmr0;
  assign o_ovf  = w_ovf;

endmodule

// File: rtl/pic_file_register.sv
// PIC16 data-memory stage: RAM, special-register readback, INTCON, OPTION_REG, Timer0, interrupt.
module pic_file_register
  import pic_pkg::*;
(
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Sync,
  input  logic [8:0] Address,
  input  logic [7:0] Write_Data,
  input  logic       Latch,
  output logic [7:0] Read_Data,
  input  logic [7:0] PCL,
  input  logic       IRP,
  input  logic [1:0] RP,
  input  logic       Carry,
  input  logic       DecimalCarry,
  input  logic       Zero,
  input  logic [7:0] FSR,
  input  logic [4:0] PCLATH,
  input  logic       GIE,
  input  logic       T0CKI,
  input  logic       INT,
  output logic       Interrupt
);

  decode_t    w_dec;
  logic       w_tmr0_we;
  logic       w_opt_we;
  logic       w_intcon_we;
  logic       w_ram_we;
  logic [7:0] w_tmr0;
  logic       w_ovf;
  logic [7:0] r_option;
  logic [6:0] r_intcon;
  logic [6:0] w_intcon_nxt;
  logic       r_int_s1;
  logic       r_int_s2;
  logic       r_int_prev;
  logic       w_int_edge;
  logic       w_irq;
  logic [7:0] w_rd_sfr;
  logic [7:0] r_ram [0:RAM_DEPTH-1];

  // Address decode and per-register write strobes.
  always_comb begin
    w_dec       = decode_addr(Address);
    w_tmr0_we   = Latch & (w_dec.sel == SEL_TMR0);
    w_opt_we    = Latch & (w_dec.sel == SEL_OPTION);
    w_intcon_we = Latch & (w_dec.sel == SEL_INTCON);
    w_ram_we    = Latch & w_dec.ram_hit;
  end

  pic_timer0 u_timer0 (
    .i_clk   (Clk),
    .i_rst   (Reset),
    .i_sync  (Sync),
    .i_t0cki (T0CKI),
    .i_t0cs  (r_option[OPT_T0CS]),
    .i_t0se  (r_option[OPT_T0SE]),
    .i_psa   (r_option[OPT_PSA]),
    .i_ps    (r_option[2:0]),
    .i_we    (w_tmr0_we),
    .i_wdata (Write_Data),
    .o_tmr0  (w_tmr0),
    .o_ovf   (w_ovf)
  );

  // Two-stage synchroniser on the INT pin plus the previous-sample edge register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_int_s1   <= 1'b0;
      r_int_s2   <= 1'b0;
      r_int_prev <= 1'b0;
    end else begin
      r_int_s1   <= INT;
      r_int_s2   <= r_int_s1;
      r_int_prev <= r_int_s2;
    end
  end

  // INT edge select, INTCON next value with hardware flag sets winning, and the request.
  always_comb begin
    if (r_option[OPT_INTEDG]) begin
      w_int_edge = r_int_s2 & ~r_int_prev;
    end else begin
      w_int_edge = ~r_int_s2 & r_int_prev;
    end
    if (w_intcon_we) begin
      w_intcon_nxt = Write_Data[6:0];
    end else begin
      w_intcon_nxt = r_intcon;
    end
    w_intcon_nxt[INT_T0IF] = w_intcon_nxt[INT_T0IF] | w_ovf;
    w_intcon_nxt[INT_INTF] = w_intcon_nxt[INT_INTF] | w_int_edge;
    w_irq = (r_intcon[INT_T0IE] & r_intcon[INT_T0IF]) |
            (r_intcon[INT_INTE] & r_intcon[INT_INTF]) |
            (r_intcon[INT_RBIE] & r_intcon[INT_RBIF]);
  end

  // OPTION_REG, INTCON and the registered interrupt request.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_option  <= 8'hFF;
      r_intcon  <= 7'h00;
      Interrupt <= 1'b0;
    end else begin
      if (w_opt_we) begin
        r_option <= Write_Data;
      end
      r_intcon  <= w_intcon_nxt;
      Interrupt <= w_irq;
    end
  end

  // Readback mux for everything that is not RAM.
  always_comb begin
    case (w_dec.sel)
      SEL_TMR0:   w_rd_sfr = w_tmr0;
      SEL_OPTION: w_rd_sfr = r_option;
      SEL_PCL:    w_rd_sfr = PCL;
      SEL_STATUS: w_rd_sfr = {IRP, RP, 2'b11, Zero, DecimalCarry, Carry};
      SEL_FSR:    w_rd_sfr = FSR;
      SEL_PCLATH: w_rd_sfr = {3'b000, PCLATH};
      SEL_INTCON: w_rd_sfr = {GIE, r_intcon};
      default:    w_rd_sfr = 8'h00;
    endcase
  end

  // Registered read data; RAM is read synchronously through the same register.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Read_Data <= 8'h00;
    end else if (w_dec.ram_hit) begin
      Read_Data <= r_ram[w_dec.ram_idx];
    end else begin
      Read_Data <= w_rd_sfr;
    end
  end

  // RAM write port; contents deliberately survive reset.
  always_ff @(posedge Clk) begin
    if (w_ram_we) begin
      r_ram[w_dec.ram_idx] <= Write_Data;
    end
  end

endmodule

// File: tb/tb_pic_file_register.sv
// Self-checking bench for pic_file_register: directed scenarios plus randomized traffic vs a model.
module tb_pic_file_register;

  logic       Clk = 1'b0;
  logic       Reset, Sync, Latch, IRP, Carry, DecimalCarry, Zero, GIE, T0CKI, INT;
  logic [8:0] Address;
  logic [7:0] Write_Data, PCL, FSR;
  logic [1:0] RP;
  logic [4:0] PCLATH;
  logic [7:0] Read_Data;
  logic       Interrupt;

  always #5 Clk = ~Clk;

  pic_file_register dut (
    .Clk(Clk), .Reset(Reset), .Sync(Sync), .Address(Address), .Write_Data(Write_Data),
    .Latch(Latch), .Read_Data(Read_Data), .PCL(PCL), .IRP(IRP), .RP(RP), .Carry(Carry),
    .DecimalCarry(DecimalCarry), .Zero(Zero), .FSR(FSR), .PCLATH(PCLATH), .GIE(GIE),
    .T0CKI(T0CKI), .INT(INT), .Interrupt(Interrupt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: whole-address RAM with common region folded onto bank 0.
  logic [7:0] m_tmr, m_opt, m_psc;
  logic [6:0] m_intc;
  logic [7:0] m_ram [512];
  bit         m_rv  [512];
  logic [2:0] m_t0h, m_inth;   // [0]=pin before last edge, [1]=one before, [2]=two before
  logic [7:0] exp_rd;
  bit         exp_known;
  logic       exp_int;
  int         sync_seen = 0;
  bit         sync_en = 1'b0;
  int         sync_phase = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int canon(input logic [8:0] a);
    if (a[6:0] >= 7'h70) return int'(a[6:0]);
    return int'(a);
  endfunction

  task automatic model_reset();
    m_tmr = 8'h00; m_opt = 8'hFF; m_psc = 8'h00; m_intc = 7'h00;
    m_t0h = 3'b000; m_inth = 3'b000;
    exp_rd = 8'h00; exp_known = 1'b1; exp_int = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs that were present at the edge.
  task automatic model_step();
    logic [6:0] off;
    bit t0_rise, t0_fall, in_rise, in_fall, tick, inc, ovf, in_edge, is_tmr, is_opt, is_intc;
    int pmax;
    if (Reset) begin
      model_reset();
      return;
    end
    if (Sync) sync_seen++;
    off = Address[6:0];
    exp_known = 1'b1;
    case (off)
      7'h01:   exp_rd = Address[7] ? m_opt : m_tmr;
      7'h02:   exp_rd = PCL;
      7'h03:   exp_rd = {IRP, RP, 2'b11, Zero, DecimalCarry, Carry};
      7'h04:   exp_rd = FSR;
      7'h0A:   exp_rd = {3'b000, PCLATH};
      7'h0B:   exp_rd = {GIE, m_intc};
      default: begin
        if (off >= 7'h20) begin
          if (m_rv[canon(Address)]) exp_rd = m_ram[canon(Address)];
          else exp_known = 1'b0;
        end else begin
          exp_rd = 8'h00;
        end
      end
    endcase
    exp_int = (m_intc[5] & m_intc[2]) | (m_intc[4] & m_intc[1]) | (m_intc[3] & m_intc[0]);
    // A pin level sampled at edge k is seen as an edge effect at edge k+2.
    t0_rise = m_t0h[1] & ~m_t0h[2];
    t0_fall = ~m_t0h[1] & m_t0h[2];
    in_rise = m_inth[1] & ~m_inth[2];
    in_fall = ~m_inth[1] & m_inth[2];
    m_t0h  = {m_t0h[1:0], T0CKI};
    m_inth = {m_inth[1:0], INT};
    if (m_opt[5]) tick = m_opt[4] ? t0_fall : t0_rise;
    else          tick = Sync;
    is_tmr  = Latch && off == 7'h01 && !Address[7];
    is_opt  = Latch && off == 7'h01 && Address[7];
    is_intc = Latch && off == 7'h0B;
    ovf = 1'b0;
    if (is_tmr) begin
      m_tmr = Write_Data;
      m_psc = 8'h00;
    end else if (tick) begin
      inc = 1'b0;
      if (m_opt[3]) begin
        inc = 1'b1;
      end else begin
        pmax = (1 << (int'(m_opt[2:0]) + 1)) - 1;
        if (int'(m_psc) == pmax) begin
          m_psc = 8'h00;
          inc = 1'b1;
        end else begin
          m_psc = m_psc + 8'd1;
        end
      end
      if (inc) begin
        if (m_tmr == 8'hFF) ovf = 1'b1;
        m_tmr = m_tmr + 8'd1;
      end
    end
    in_edge = m_opt[6] ? in_rise : in_fall;
    if (is_opt) m_opt = Write_Data;
    if (is_intc) m_intc = Write_Data[6:0];
    if (ovf) m_intc[2] = 1'b1;
    if (in_edge) m_intc[1] = 1'b1;
    if (Latch && off >= 7'h20) begin
      m_ram[canon(Address)] = Write_Data;
      m_rv[canon(Address)]  = 1'b1;
    end
  endtask

  // One clock: model update at the edge, compare shortly after, then prepare next Sync.
  task automatic tick();
    @(posedge Clk);
    model_step();
    #1;
    if (exp_known) check("read_data", Read_Data, exp_rd);
    check("interrupt", {7'b0000000, Interrupt}, {7'b0000000, exp_int});
    if (sync_en) begin
      sync_phase = (sync_phase + 1) % 4;
      Sync = (sync_phase == 0);
    end else begin
      Sync = 1'b0;
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    Address = a; Write_Data = d; Latch = 1'b1;
    tick();
    Latch = 1'b0;
  endtask

  task automatic rd(input logic [8:0] a, output logic [7:0] v);
    Address = a; Latch = 1'b0;
    tick();
    v = Read_Data;
  endtask

  task automatic pulse_t0(input int n);
    for (int i = 0; i < n; i++) begin
      T0CKI = 1'b1; repeat (3) tick();
      T0CKI = 1'b0; repeat (3) tick();
    end
    repeat (3) tick();
  endtask

  initial begin
    logic [7:0] v;
    int target;
    Reset = 1'b1; Sync = 1'b0; Latch = 1'b0; Address = 9'h000; Write_Data = 8'h00;
    PCL = 8'h00; IRP = 1'b0; RP = 2'b00; Carry = 1'b0; DecimalCarry = 1'b0; Zero = 1'b0;
    FSR = 8'h00; PCLATH = 5'h00; GIE = 1'b0; T0CKI = 1'b0; INT = 1'b0;
    model_reset();
    repeat (3) tick();
    Reset = 1'b0;

    // Reset values.
    rd(9'h001, v); check("rst_tmr0", v, 8'h00);
    rd(9'h081, v); check("rst_option", v, 8'hFF);
    rd(9'h00B, v); check("rst_intcon", v, 8'h00);

    // STATUS readback, writes ignored.
    IRP = 1'b1; RP = 2'b10; Zero = 1'b1; DecimalCarry = 1'b0; Carry = 1'b1;
    rd(9'h003, v); check("status", v, 8'hDD);
    wr(9'h003, 8'h00);
    rd(9'h183, v); check("status_wr_ignored", v, 8'hDD);

    // Common and banked RAM.
    wr(9'h0F5, 8'hA5);
    rd(9'h175, v); check("common_175", v, 8'hA5);
    rd(9'h1F5, v); check("common_1f5", v, 8'hA5);
    wr(9'h1F0, 8'h5A);
    rd(9'h070, v); check("common_070", v, 8'h5A);
    wr(9'h06F, 8'h11);
    wr(9'h0EF, 8'h22);
    rd(9'h06F, v); check("bank0_06f", v, 8'h11);
    rd(9'h0EF, v); check("bank1_0ef", v, 8'h22);

    // TMR0 overflow from Sync with divide-by-2.
    wr(9'h00B, 8'h20);
    wr(9'h081, 8'h00);
    wr(9'h001, 8'hFE);
    sync_en = 1'b1;
    target = sync_seen + 4;
    for (int i = 0; i < 64 && sync_seen < target; i++) tick();
    check("sync_wait", {7'b0000000, sync_seen >= target}, 8'h01);
    sync_en = 1'b0; Sync = 1'b0;
    check("irq_not_yet", {7'b0000000, Interrupt}, 8'h00);
    rd(9'h00B, v); check("t0if_set", v, 8'h24);
    check("irq_t0", {7'b0000000, Interrupt}, 8'h01);
    rd(9'h001, v); check("tmr0_wrapped", v, 8'h00);
    wr(9'h00B, 8'h00);

    // T0CKI rising then falling edge counting, no prescaler.
    wr(9'h081, 8'h28);
    wr(9'h001, 8'h10);
    pulse_t0(5);
    rd(9'h001, v); check("t0cki_rise", v, 8'h15);
    wr(9'h081, 8'h38);
    wr(9'h001, 8'h10);
    pulse_t0(5);
    rd(9'h001, v); check("t0cki_fall", v, 8'h15);

    // INT rising edge coinciding with an INTCON write.
    wr(9'h081, 8'h40);
    INT = 1'b1;
    tick(); tick();
    wr(9'h00B, 8'h10);
    rd(9'h00B, v); check("intf_wins", v, 8'h12);
    check("irq_int", {7'b0000000, Interrupt}, 8'h01);
    wr(9'h00B, 8'h10);
    rd(9'h00B, v); check("intf_cleared", v, 8'h10);
    INT = 1'b0;

    // Asynchronous reset in the middle of a cycle.
    wr(9'h00B, 8'h24);
    wr(9'h081, 8'h00);
    wr(9'h001, 8'h37);
    rd(9'h001, v); check("pre_rst_tmr0", v, 8'h37);
    check("pre_rst_irq", {7'b0000000, Interrupt}, 8'h01);
    #2;
    Reset = 1'b1;
    #1;
    check("async_rst_rd", Read_Data, 8'h00);
    check("async_rst_irq", {7'b0000000, Interrupt}, 8'h00);
    model_reset();
    tick();
    Reset = 1'b0;
    rd(9'h001, v); check("post_rst_tmr0", v, 8'h00);
    rd(9'h081, v); check("post_rst_option", v, 8'hFF);
    rd(9'h00B, v); check("post_rst_intcon", v, 8'h00);

    // Randomized traffic against the model.
    sync_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0:       Address = 9'h001;
        1:       Address = 9'h081;
        2:       Address = 9'h101;
        3:       Address = 9'h10B;
        4:       Address = 9'h18B;
        default: Address = 9'($urandom);
      endcase
      Latch = ($urandom_range(0, 3) == 0);
      Write_Data = 8'($urandom);
      PCL = 8'($urandom); FSR = 8'($urandom); PCLATH = 5'($urandom); RP = 2'($urandom);
      IRP = 1'($urandom); Carry = 1'($urandom); DecimalCarry = 1'($urandom);
      Zero = 1'($urandom); GIE = 1'($urandom);
      if ($urandom_range(0, 2) == 0) T0CKI = ~T0CKI;
      if ($urandom_range(0, 3) == 0) INT = ~INT;
      tick();
    end
    Latch = 1'b0;

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
